// File: rtl/selfcomp_pkg.sv
// Shared types and helpers for the self-composition timing-leak monitor.
package selfcomp_pkg;

    localparam int unsigned MAX_COPIES = 8;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SKEW,
        CLOSE
    } state_e;

    // Increment that sticks at max_value instead of wrapping.
    function automatic int unsigned sat_inc(input int unsigned value, input int unsigned max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/selfcomp_first_finder.sv
// Lowest-index priority encoder over the copies completing this cycle.
module selfcomp_first_finder
    import selfcomp_pkg::*;
#(
    parameter int unsigned NUM_COPIES = 2
) (
    input  logic [NUM_COPIES-1:0] req,
    output logic [IDX_W-1:0]      idx_c,
    output logic                  any_c
);

    // Scan downward so the lowest set index is the last one written.
    always_comb begin
        idx_c = '0;
        any_c = 1'b0;
        for (int i = NUM_COPIES - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c = IDX_W'(i);
                any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/selfcomp_leak_monitor.sv
// Completion-skew and timeout monitor across N identically driven SE copies.
// Define RESULT_CHECK_EN to also compare the copies' results against the first finisher.
module selfcomp_leak_monitor
    import selfcomp_pkg::*;
#(
    parameter int unsigned NUM_COPIES = 2,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned TIMEOUT    = 200
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         issue,
    input  logic [NUM_COPIES-1:0]        copy_valid,
    input  logic [NUM_COPIES*DATA_W-1:0] copy_result,
    output logic                         busy,
    output logic                         done,
    output logic                         timing_leak,
    output logic                         timeout,
    output logic                         all_valid,
    output logic [IDX_W-1:0]             first_copy,
    output logic [CNT_W-1:0]             latency,
    output logic [CNT_W-1:0]             skew,
    output logic                         result_mismatch
);

    localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    state_e                state, state_d;
    logic [NUM_COPIES-1:0] seen, seen_d, seen_nx, pending_c;
    logic [CNT_W-1:0]      lat_cnt, lat_cnt_d, skew_cnt, skew_cnt_d;
    logic [CNT_W-1:0]      lat_inc, skew_inc, latency_d, skew_d;
    logic [IDX_W-1:0]      first_copy_d, pend_idx;
    logic                  busy_d, done_d, timing_leak_d, timeout_d, all_valid_d;
    logic                  pend_any, all_seen, expired, close_now, in_txn;

    // Valids only count while a transaction is open and the copy has not finished yet.
    assign in_txn    = (state == WAIT) || (state == SKEW);
    assign pending_c = in_txn ? (copy_valid & ~seen) : '0;

    selfcomp_first_finder #(
        .NUM_COPIES (NUM_COPIES)
    ) u_first_finder (
        .req   (pending_c),
        .idx_c (pend_idx),
        .any_c (pend_any)
    );

    always_comb begin
        state_d       = state;
        seen_d        = seen;
        lat_cnt_d     = lat_cnt;
        skew_cnt_d    = skew_cnt;
        latency_d     = latency;
        skew_d        = skew;
        first_copy_d  = first_copy;
        busy_d        = busy;
        done_d        = 1'b0;
        timing_leak_d = timing_leak;
        timeout_d     = timeout;
        all_valid_d   = all_valid;
        close_now     = 1'b0;
        seen_nx       = seen | pending_c;
        all_seen      = &seen_nx;
        lat_inc       = CNT_W'(sat_inc(32'(lat_cnt), CNT_MAX));
        skew_inc      = CNT_W'(sat_inc(32'(skew_cnt), CNT_MAX));
        expired       = lat_inc >= CNT_W'(TIMEOUT);

        case (state)
            IDLE: begin
                if (issue) begin
                    state_d     = WAIT;
                    seen_d      = '0;
                    lat_cnt_d   = '0;
                    skew_cnt_d  = '0;
                    busy_d      = 1'b1;
                    all_valid_d = 1'b0;
                end
            end
            WAIT: begin
                lat_cnt_d = lat_inc;
                seen_d    = seen_nx;
                if (pend_any) begin
                    latency_d    = lat_inc;
                    first_copy_d = pend_idx;
                    skew_cnt_d   = '0;
                    state_d      = SKEW;
                    if (all_seen || expired) begin
                        close_now = 1'b1;
                        skew_d    = '0;
                    end
                end else if (expired) begin
                    close_now    = 1'b1;
                    latency_d    = '0;
                    first_copy_d = '0;
                    skew_d       = '0;
                end
            end
            SKEW: begin
                lat_cnt_d  = lat_inc;
                skew_cnt_d = skew_inc;
                seen_d     = seen_nx;
                if (all_seen || expired) begin
                    close_now = 1'b1;
                    skew_d    = skew_inc;
                end
            end
            CLOSE: begin
                state_d     = IDLE;
                all_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Full completion wins over a timeout landing on the same cycle.
        if (close_now) begin
            state_d       = CLOSE;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            all_valid_d   = all_seen;
            timeout_d     = timeout | ~all_seen;
            timing_leak_d = timing_leak | (skew_d != '0) | (~all_seen & (|seen_nx));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            seen        <= '0;
            lat_cnt     <= '0;
            skew_cnt    <= '0;
            latency     <= '0;
            skew        <= '0;
            first_copy  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timing_leak <= 1'b0;
            timeout     <= 1'b0;
            all_valid   <= 1'b0;
        end else begin
            state       <= state_d;
            seen        <= seen_d;
            lat_cnt     <= lat_cnt_d;
            skew_cnt    <= skew_cnt_d;
            latency     <= latency_d;
            skew        <= skew_d;
            first_copy  <= first_copy_d;
            busy        <= busy_d;
            done        <= done_d;
            timing_leak <= timing_leak_d;
            timeout     <= timeout_d;
            all_valid   <= all_valid_d;
        end
    end

`ifdef RESULT_CHECK_EN
    logic [DATA_W-1:0] ref_reg, ref_d, first_result_c, cmp_ref_c;
    logic              mismatch_q, mismatch_d;

    // Same-cycle finishers compare against the value being captured, later ones against ref_reg.
    always_comb begin
        first_result_c = '0;
        for (int i = 0; i < NUM_COPIES; i++) begin
            if (pend_idx == IDX_W'(i)) begin
                first_result_c = copy_result[i*DATA_W +: DATA_W];
            end
        end
        cmp_ref_c  = (state == WAIT) ? first_result_c : ref_reg;
        ref_d      = ((state == WAIT) && pend_any) ? first_result_c : ref_reg;
        mismatch_d = mismatch_q;
        for (int i = 0; i < NUM_COPIES; i++) begin
            if (pending_c[i] && (copy_result[i*DATA_W +: DATA_W] != cmp_ref_c)) begin
                mismatch_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ref_reg    <= '0;
            mismatch_q <= 1'b0;
        end else begin
            ref_reg    <= ref_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign result_mismatch = mismatch_q;
`else
    logic unused_result;
    assign unused_result   = ^copy_result;
    assign result_mismatch = 1'b0;
`endif

endmodule
